letter_wrap_pipeline: RTL and testbench

Parametrised, pipelined successor to the single-cycle letter overflow comparator. Applies a rotor offset to an uppercase letter code in either direction, detects overflow past Z or underflow below A, and wraps the result back into the alphabet. Sits between the keyboard/rotor-position logic and each rotor stage of the Enigma datapath. Uses a valid/ready handshake and keeps a count of wrap events for on-board debug display.

---
 rtl/letter_wrap_pipeline_pkg.sv | 16 +
 rtl/letter_wrap_pipeline_if.sv | 35 +++
 rtl/letter_wrap_pipeline_stage.sv | 39 +++
 rtl/letter_wrap_pipeline.sv | 146 ++++++++++++++
 tb/tb_letter_wrap_pipeline.sv | 333 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/letter_wrap_pipeline_pkg.sv
// Shared letter constants and default widths for the Enigma letter datapath.
// Imported by letter_overflow_comparator, the rotor stages and this pipeline.
package letter_wrap_pipeline_pkg;

  localparam int unsigned LETTER_A   = 65;
  localparam int unsigned LETTER_Z   = 90;
  localparam int unsigned ALPHA_SIZE = LETTER_Z - LETTER_A + 1;

  localparam int unsigned DEF_CHAR_W = 8;
  localparam int unsigned DEF_OFF_W  = 5;
  localparam int unsigned DEF_CNT_W  = 16;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

endpackage

// File: rtl/letter_wrap_pipeline_if.sv
// Valid/ready stream bundle for letter_wrap_pipeline.
//   in_valid/in_ready + in_char/in_offset/in_dir : request side
//   out_valid/out_ready + out_char/out_wrapped/out_err : result side
// slave  : the pipeline's view (consumes requests, produces results)
// master : the upstream/downstream environment's view
interface letter_wrap_pipeline_if
  import letter_wrap_pipeline_pkg::*;
#(
  parameter int unsigned CHAR_W = DEF_CHAR_W,
  parameter int unsigned OFF_W  = DEF_OFF_W
);

  logic              in_valid;
  logic              in_ready;
  logic [CHAR_W-1:0] in_char;
  logic [OFF_W-1:0]  in_offset;
  logic              in_dir;

  logic              out_valid;
  logic              out_ready;
  logic [CHAR_W-1:0] out_char;
  logic              out_wrapped;
  logic              out_err;

  modport slave (
    input  in_valid, in_char, in_offset, in_dir, out_ready,
    output in_ready, out_valid, out_char, out_wrapped, out_err
  );

  modport master (
    output in_valid, in_char, in_offset, in_dir, out_ready,
    input  in_ready, out_valid, out_char, out_wrapped, out_err
  );

endinterface

// File: rtl/letter_wrap_pipeline_stage.sv
// letter_wrap_stage: combinational offset sum, range flags and input check.
//   chr, offset, dir : letter code, offset magnitude, 0=add / 1=subtract
//   sum              : chr +/- offset, CHAR_W+1 bits signed (no aliasing below 0)
//   over, under      : sum past the last letter / below the first letter
//   err              : chr outside the alphabet or offset >= ALPHA_LEN
module letter_wrap_stage
  import letter_wrap_pipeline_pkg::*;
#(
  parameter int unsigned CHAR_W    = DEF_CHAR_W,
  parameter int unsigned OFF_W     = DEF_OFF_W,
  parameter int unsigned BASE      = LETTER_A,
  parameter int unsigned ALPHA_LEN = ALPHA_SIZE
) (
  input  logic                     dir,
  input  logic [CHAR_W-1:0]        chr,
  input  logic [OFF_W-1:0]         offset,
  output logic signed [CHAR_W:0]   sum,
  output logic                     over,
  output logic                     under,
  output logic                     err
);

  localparam int unsigned SUM_W = CHAR_W + 1;
  localparam int unsigned LAST  = BASE + ALPHA_LEN - 1;

  logic signed [SUM_W-1:0] chr_s;
  logic signed [SUM_W-1:0] off_s;

  // Both operands zero-extended into the signed domain before the add/sub.
  always_comb begin
    chr_s = $signed({1'b0, chr});
    off_s = $signed(SUM_W'(offset));
    sum   = dir ? (chr_s - off_s) : (chr_s + off_s);
    over  = (sum > $signed(SUM_W'(LAST)));
    under = (sum < $signed(SUM_W'(BASE)));
    err   = (32'(chr) < BASE) || (32'(chr) > LAST) || (32'(offset) >= ALPHA_LEN);
  end

endmodule

// File: rtl/letter_wrap_pipeline.sv
// letter_wrap_pipeline: two-stage rotor-offset apply with alphabet wrap.
//   clk, resetn : clock, asynchronous active-low reset
//   bus         : valid/ready stream (request: char/offset/dir,
//                 result: char/wrapped/err)
//   clr_count   : synchronous clear of wrap_count (wins over an increment)
//   wrap_count  : saturating count of consumed wrapped results
// S1 registers the sum and flags, S2 applies the wrap and holds the output.
module letter_wrap_pipeline
  import letter_wrap_pipeline_pkg::*;
#(
  parameter int unsigned CHAR_W    = DEF_CHAR_W,
  parameter int unsigned BASE      = LETTER_A,
  parameter int unsigned ALPHA_LEN = ALPHA_SIZE,
  parameter int unsigned OFF_W     = DEF_OFF_W,
  parameter int unsigned CNT_W     = DEF_CNT_W
) (
  input  logic                   clk,
  input  logic                   resetn,
  letter_wrap_pipeline_if.slave  bus,
  input  logic                   clr_count,
  output logic [CNT_W-1:0]       wrap_count
);

  localparam int unsigned SUM_W = CHAR_W + 1;

  // Stage 1 contents
  logic                    s1_valid;
  logic [CHAR_W-1:0]       s1_char;
  logic                    s1_dir;
  logic signed [SUM_W-1:0] s1_sum;
  logic                    s1_over;
  logic                    s1_under;
  logic                    s1_err;

  // Stage 2 / output register
  logic                    out_valid_q;
  logic [CHAR_W-1:0]       out_char_q;
  logic                    out_wrapped_q;
  logic                    out_err_q;

  logic signed [SUM_W-1:0] st_sum;
  logic                    st_over;
  logic                    st_under;
  logic                    st_err;

  logic                    s2_can_load_c;
  logic                    in_ready_c;
  logic                    consume_c;
  logic [CHAR_W-1:0]       wrap_char_c;
  logic                    wrap_hit_c;

  letter_wrap_stage #(
    .CHAR_W    (CHAR_W),
    .OFF_W     (OFF_W),
    .BASE      (BASE),
    .ALPHA_LEN (ALPHA_LEN)
  ) u_stage (
    .dir    (bus.in_dir),
    .chr    (bus.in_char),
    .offset (bus.in_offset),
    .sum    (st_sum),
    .over   (st_over),
    .under  (st_under),
    .err    (st_err)
  );

  // Handshake: ready depends only on stage occupancy and out_ready.
  always_comb begin
    s2_can_load_c = !out_valid_q || bus.out_ready;
    in_ready_c    = !s1_valid || s2_can_load_c;
    consume_c     = out_valid_q && bus.out_ready;
  end

  // Wrap select: only the flag matching the direction is honoured.
  always_comb begin
    wrap_char_c = CHAR_W'(s1_sum);
    wrap_hit_c  = FALSE;
    if (s1_err) begin
      wrap_char_c = s1_char;
    end else if (!s1_dir && s1_over) begin
      wrap_char_c = CHAR_W'(s1_sum - $signed(SUM_W'(ALPHA_LEN)));
      wrap_hit_c  = TRUE;
    end else if (s1_dir && s1_under) begin
      wrap_char_c = CHAR_W'(s1_sum + $signed(SUM_W'(ALPHA_LEN)));
      wrap_hit_c  = TRUE;
    end
  end

  // Stage 1 register: loads whenever it is empty or draining into S2.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1_valid <= FALSE;
      s1_char  <= '0;
      s1_dir   <= FALSE;
      s1_sum   <= '0;
      s1_over  <= FALSE;
      s1_under <= FALSE;
      s1_err   <= FALSE;
    end else if (in_ready_c) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_char  <= bus.in_char;
        s1_dir   <= bus.in_dir;
        s1_sum   <= st_sum;
        s1_over  <= st_over;
        s1_under <= st_under;
        s1_err   <= st_err;
      end
    end
  end

  // Stage 2 / output register: fields hold while stalled.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_valid_q   <= FALSE;
      out_char_q    <= '0;
      out_wrapped_q <= FALSE;
      out_err_q     <= FALSE;
    end else if (s2_can_load_c) begin
      out_valid_q <= s1_valid;
      if (s1_valid) begin
        out_char_q    <= wrap_char_c;
        out_wrapped_q <= wrap_hit_c;
        out_err_q     <= s1_err;
      end
    end
  end

  // Wrap event counter, saturating; clear has priority.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wrap_count <= '0;
    end else if (clr_count) begin
      wrap_count <= '0;
    end else if (consume_c && out_wrapped_q && (wrap_count != '1)) begin
      wrap_count <= wrap_count + CNT_W'(1);
    end
  end

  assign bus.in_ready    = in_ready_c;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_char    = out_char_q;
  assign bus.out_wrapped = out_wrapped_q;
  assign bus.out_err     = out_err_q;

endmodule

// File: tb/tb_letter_wrap_pipeline.sv
// Self-checking bench for letter_wrap_pipeline: directed cases, stall,
// randomized streams against a letter-arithmetic model, reset, saturation.
module tb_letter_wrap_pipeline;

  logic        clk;
  logic        resetn;
  logic        clr_count;
  logic [15:0] wrap_count;

  letter_wrap_pipeline_if bus ();

  letter_wrap_pipeline dut (
    .clk        (clk),
    .resetn     (resetn),
    .bus        (bus),
    .clr_count  (clr_count),
    .wrap_count (wrap_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Expected / observed results as {char, wrapped, err}
  logic [9:0] exp_q [$];
  logic [9:0] obs_q [$];
  bit         cnt_q [$];
  int         exp_cnt = 0;

  // Reference: plain letter arithmetic on integers.
  function automatic logic [9:0] ref_wrap(input int c, input int o, input bit d);
    int v;
    if (c < 65 || c > 90 || o >= 26) return {8'(c), 2'b01};
    v = d ? c - o : c + o;
    if (v > 90) return {8'(v - 26), 2'b10};
    if (v < 65) return {8'(v + 26), 2'b10};
    return {8'(v), 2'b00};
  endfunction

  task automatic push_expect(input int c, input int o, input bit d);
    logic [9:0] e;
    e = ref_wrap(c, o, d);
    exp_q.push_back(e);
    cnt_q.push_back(e[1]);
  endtask

  task automatic drive_in(input int c, input int o, input bit d);
    bus.in_valid  = 1'b1;
    bus.in_char   = 8'(c);
    bus.in_offset = 5'(o);
    bus.in_dir    = d;
  endtask

  // Output monitor and counter model, sampled mid-cycle.
  always @(negedge clk) begin
    if (!resetn) begin
      exp_cnt = 0;
      cnt_q.delete();
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        obs_q.push_back({bus.out_char, bus.out_wrapped, bus.out_err});
        if (cnt_q.size() > 0) begin
          if (cnt_q.pop_front() && !clr_count && exp_cnt < 65535) exp_cnt++;
        end
      end
      if (clr_count) exp_cnt = 0;
    end
  end

  task automatic test_reset();
    resetn = 1'b0; clr_count = 1'b0;
    bus.in_valid = 1'b0; bus.in_char = '0; bus.in_offset = '0; bus.in_dir = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready);
    else n_pass++;
    n_checks++;
    if ({bus.out_valid, bus.out_char, bus.out_wrapped, bus.out_err} !== 11'd0)
      $display("FAIL reset_outputs: got %b/%h/%b/%b expected all 0",
               bus.out_valid, bus.out_char, bus.out_wrapped, bus.out_err);
    else n_pass++;
    n_checks++;
    if (wrap_count !== 16'd0) $display("FAIL reset_count: got %h expected 0", wrap_count);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    int         dc   [8] = '{89, 67, 77, 97, 65, 65, 90, 65};
    int         doff [8] = '{3, 5, 0, 2, 26, 25, 1, 1};
    bit         ddir [8] = '{0, 1, 1, 0, 0, 0, 0, 1};
    logic [9:0] dres [8] = '{{8'd66, 2'b10}, {8'd88, 2'b10}, {8'd77, 2'b00}, {8'd97, 2'b01},
                             {8'd65, 2'b01}, {8'd90, 2'b00}, {8'd65, 2'b10}, {8'd90, 2'b10}};
    int         dcnt [8] = '{1, 2, 2, 2, 2, 2, 3, 4};
    logic [10:0] got;
    for (int i = 0; i < 8; i++) begin
      bus.out_ready = 1'b1;
      drive_in(dc[i], doff[i], ddir[i]);
      @(negedge clk);
      n_checks++;
      if (bus.in_ready !== 1'b1) $display("FAIL dir%0d_in_ready: got %b expected 1", i, bus.in_ready);
      else n_pass++;
      push_expect(dc[i], doff[i], ddir[i]);
      @(posedge clk); #1 bus.in_valid = 1'b0;
      @(negedge clk);
      n_checks++;
      if (bus.out_valid !== 1'b0) $display("FAIL dir%0d_early_valid: got %b expected 0", i, bus.out_valid);
      else n_pass++;
      @(posedge clk); #1;
      @(negedge clk);
      got = {bus.out_valid, bus.out_char, bus.out_wrapped, bus.out_err};
      n_checks++;
      if (got !== {1'b1, dres[i]}) $display("FAIL dir%0d_result: got %h expected %h", i, got, {1'b1, dres[i]});
      else n_pass++;
      @(posedge clk); #1;
      @(negedge clk);
      n_checks++;
      if (wrap_count !== 16'(dcnt[i])) $display("FAIL dir%0d_count: got %0d expected %0d", i, wrap_count, dcnt[i]);
      else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_stall();
    int          sent = 0;
    int          k = 0;
    bit          acc;
    logic [10:0] snap = '0;
    logic [10:0] got;
    exp_q.delete(); obs_q.delete();
    while (obs_q.size() < 6 && k < 60) begin
      bus.out_ready = !(k >= 3 && k <= 5);
      if (!bus.in_valid && sent < 6)
        drive_in(int'($urandom_range(90, 65)), int'($urandom_range(25)), 1'($urandom_range(1)));
      @(negedge clk);
      acc = bus.in_valid && bus.in_ready;
      if (acc) begin
        push_expect(int'(bus.in_char), int'(bus.in_offset), bus.in_dir);
        sent++;
      end
      got = {bus.out_valid, bus.out_char, bus.out_wrapped, bus.out_err};
      if (k == 3 && exp_q.size() > 1) begin
        snap = got;
        n_checks++;
        if (got !== {1'b1, exp_q[1]}) $display("FAIL stall_head: got %h expected %h", got, {1'b1, exp_q[1]});
        else n_pass++;
      end
      if (k == 4 || k == 5) begin
        n_checks++;
        if (got !== snap) $display("FAIL stall_hold_k%0d: got %h expected %h", k, got, snap);
        else n_pass++;
      end
      if (k == 4) begin
        n_checks++;
        if (bus.in_ready !== 1'b0) $display("FAIL stall_in_ready: got %b expected 0", bus.in_ready);
        else n_pass++;
      end
      @(posedge clk); #1;
      if (acc) bus.in_valid = 1'b0;
      k++;
    end
    n_checks++;
    if (obs_q.size() != 6) $display("FAIL stall_count: got %0d results expected 6", obs_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i])
        $display("FAIL stall_item%0d: got %h expected %h", i, (i < obs_q.size()) ? obs_q[i] : 10'h3ff, exp_q[i]);
      else n_pass++;
    end
  endtask

  task automatic run_stream(input int n, input int ready_pct, input int valid_pct,
                            input int err_pct, output int iters);
    int sent = 0;
    int c, o;
    bit acc;
    iters = 0;
    exp_q.delete(); obs_q.delete();
    while (obs_q.size() < n && iters < 20 * n + 100) begin
      bus.out_ready = (int'($urandom_range(99)) < ready_pct);
      if (!bus.in_valid && sent < n && int'($urandom_range(99)) < valid_pct) begin
        c = (int'($urandom_range(99)) < err_pct) ? int'($urandom_range(255)) : int'($urandom_range(90, 65));
        o = (int'($urandom_range(99)) < err_pct) ? int'($urandom_range(31)) : int'($urandom_range(25));
        drive_in(c, o, 1'($urandom_range(1)));
      end
      @(negedge clk);
      acc = bus.in_valid && bus.in_ready;
      if (acc) begin
        push_expect(int'(bus.in_char), int'(bus.in_offset), bus.in_dir);
        sent++;
      end
      @(posedge clk); #1;
      if (acc) bus.in_valid = 1'b0;
      iters++;
    end
    bus.in_valid = 1'b0;
    n_checks++;
    if (obs_q.size() != n) $display("FAIL stream_count: got %0d results expected %0d", obs_q.size(), n);
    else n_pass++;
  endtask

  task automatic test_random();
    int iters;
    run_stream(300, 60, 75, 15, iters);
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i])
        $display("FAIL rand_item%0d: got %h expected %h", i, (i < obs_q.size()) ? obs_q[i] : 10'h3ff, exp_q[i]);
      else n_pass++;
    end
    n_checks++;
    if (wrap_count !== 16'(exp_cnt)) $display("FAIL rand_count: got %0d expected %0d", wrap_count, exp_cnt);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int iters;
    run_stream(50, 100, 100, 0, iters);
    n_checks++;
    if (iters != 52) $display("FAIL b2b_cycles: got %0d expected 52", iters);
    else n_pass++;
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i])
        $display("FAIL b2b_item%0d: got %h expected %h", i, (i < obs_q.size()) ? obs_q[i] : 10'h3ff, exp_q[i]);
      else n_pass++;
    end
    n_checks++;
    if (wrap_count !== 16'(exp_cnt)) $display("FAIL b2b_count: got %0d expected %0d", wrap_count, exp_cnt);
    else n_pass++;
  endtask

  task automatic test_reset_inflight();
    bus.out_ready = 1'b0;
    drive_in(89, 3, 0);
    @(posedge clk); #1;
    drive_in(67, 5, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    n_checks++;
    if (bus.out_valid !== 1'b1) $display("FAIL inflight_valid: got %b expected 1", bus.out_valid);
    else n_pass++;
    #2 resetn = 1'b0;
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0) $display("FAIL async_reset_valid: got %b expected 0", bus.out_valid);
    else n_pass++;
    n_checks++;
    if (wrap_count !== 16'd0) $display("FAIL async_reset_count: got %0d expected 0", wrap_count);
    else n_pass++;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    bus.out_ready = 1'b1;
    obs_q.delete();
    repeat (6) @(negedge clk);
    n_checks++;
    if (obs_q.size() != 0 || bus.out_valid !== 1'b0)
      $display("FAIL stale_after_reset: got %0d results valid=%b expected 0", obs_q.size(), bus.out_valid);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_saturate();
    int w = 0;
    bus.out_ready = 1'b1;
    drive_in(89, 3, 0);
    repeat (65540) @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    obs_q.delete();
    @(negedge clk);
    n_checks++;
    if (wrap_count !== 16'hffff) $display("FAIL sat_count: got %h expected ffff", wrap_count);
    else n_pass++;
    // Clear coincident with a wrapped consume.
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    drive_in(89, 3, 0);
    @(posedge clk); #1 bus.in_valid = 1'b0;
    while (!bus.out_valid && w < 10) begin
      @(posedge clk); #1;
      w++;
    end
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_wrapped !== 1'b1)
      $display("FAIL clr_setup: got valid=%b wrapped=%b expected 1/1", bus.out_valid, bus.out_wrapped);
    else n_pass++;
    bus.out_ready = 1'b1;
    clr_count = 1'b1;
    @(posedge clk); #1;
    clr_count = 1'b0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if (wrap_count !== 16'd0 || bus.out_valid !== 1'b0)
      $display("FAIL clr_wins: got count=%0d valid=%b expected 0/0", wrap_count, bus.out_valid);
    else n_pass++;
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    drive_in(90, 1, 0);
    @(posedge clk); #1 bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (wrap_count !== 16'd1) $display("FAIL count_after_clr: got %0d expected 1", wrap_count);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stall();
    test_random();
    test_back_to_back();
    test_reset_inflight();
    test_saturate();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks", n_pass, n_checks);
    $fatal(1);
  end

endmodule
